data_sram_resp: RTL and testbench
=================================

// Module: data_sram_resp
// PURPOSE
//  Responder end of the pipeline's data_sram port. The EX stage drives en/we/addr/wdata;
//  MEM samples rdata on the following cycle. Implements a synchronous, byte-lane-writable
//  data RAM with 1-cycle read latency. Adds a post-reset clear sequencer, a ready flag
//  and an out-of-window address error flag. Used as the data memory in the CPU testbench
//  and the FPGA top.
// PARAMETERS
//  ADDR_W          10            word-index width; DEPTH = 2**ADDR_W words
//  BASE_ADDR       32'h1c80_0000 window base; bits [31:ADDR_W+2] must match
//  CLEAR_ON_RESET  1             1: zero every word after reset; 0: skip the clear
// PORTS
//  clk              in   1   clock
//  reset            in   1   synchronous, active-high reset
//  data_sram_en     in   1   request valid (read, or write when we!=0)
//  data_sram_we     in   4   byte-lane write strobes; lane i = wdata[8i+7:8i]
//  data_sram_addr   in   32  byte address; [1:0] ignored, lanes come from we
//  data_sram_wdata  in   32  write data, already lane-replicated by the requester
//  data_sram_rdata  out  32  read data, registered, valid the cycle after en
//  sram_ready       out  1   1 = clear done, requests are serviced
//  sram_addr_err    out  1   1-cycle pulse, the cycle after an out-of-window request
// BEHAVIOUR
//  Reset (any cycle, including mid-clear): state<=CLEAR (or READY if CLEAR_ON_RESET=0),
//   clr_idx<=0, rdata<=0, sram_ready<=0, sram_addr_err<=0. RAM contents not reset directly.
//  FSM:
//   - CLEAR: each cycle mem[clr_idx]<=0, clr_idx++. When clr_idx==DEPTH-1, go to READY
//     (DEPTH cycles total).
//   - READY: stays in READY until reset.
//   - sram_ready is registered and equals (state==READY). It rises the cycle after the
//     last clear write.
//  In CLEAR, all requests are dropped: no write, rdata<=0, no err.
//  Request decode (READY, en=1):
//   - idx = addr[ADDR_W+1:2].
//   - in_win = (addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]).
//  in_win, we==0: rdata <= mem[idx].
//  in_win, we!=0:
//   - Lanes with we[i]=1 are written; other lanes keep their value.
//   - rdata <= pre-write word (read-first).
//   - A read of the same idx on the next cycle returns the merged new word.
//  !in_win: no write, rdata<=0, sram_addr_err<=1 for one cycle.
//  en=0: no access; rdata holds its previous value. we!=0 with en=0 is ignored.
//  Back-to-back requests are accepted every cycle. There is no backpressure and no stall.
//  Latency is fixed at 1.
//  Misaligned strobe patterns (e.g. 4'b0110) are written as given. No checking is done.
// STRUCTURE
//  Shared package (mycpu_pkg):
//   - DATA_BASE_ADDR, DATA_ADDR_W
//   - state encoding ST_CLEAR=1'b0, ST_READY=1'b1
//  Sub-module sram_bank_be: DEPTH x 32 array with 4 byte-enable write lanes, a read-first
//   registered port and a separate clear-write port (muxed in this block by state).
//   It maps to BRAM on FPGA.
//  This block holds the FSM, clr_idx counter, window decode, the rdata hold mux and the
//   err register.
// TESTING
//  1. Reset 1 cycle, then idle:
//     - sram_ready=0 for exactly DEPTH cycles, then 1.
//     - Reading idx 0, 5 and DEPTH-1 returns 0.
//  2. Full-word write then read (after ready):
//     - Write we=4'hF, addr=BASE+0x10, wdata=0x12345678.
//     - Next cycle read BASE+0x10; rdata=0x12345678 one cycle later.
//  3. Byte lanes on a word holding 0x12345678:
//     - we=4'b0100, wdata=0xAAAAAAAA: read gives 0x12AA5678.
//     - Then we=4'b1100, wdata=0xBEEFBEEF: read gives 0xBEEF5678.
//  4. Read-first: with mem=0x11111111, write 0x22222222 (we=F).
//     - rdata for that cycle=0x11111111; a read the next cycle gives 0x22222222.
//  5. Out of window: read or write at addr=0x0000_0040.
//     - sram_addr_err=1 for one cycle, rdata=0, no location modified.
//     - Then en=0 for 3 cycles: rdata stays 0, err 0.
//  6. Reset asserted at clr_idx=100:
//     - The clear restarts from 0, and sram_ready rises DEPTH cycles after reset deasserts.
//     - A write issued during CLEAR is lost (readback 0).

Source files
------------

// File: rtl/data_sram_resp_pkg.sv
// Shared constants, FSM state encoding and the address-window helper for the
// data SRAM responder.
package data_sram_resp_pkg;

  localparam int unsigned DATA_ADDR_W    = 10;
  localparam logic [31:0] DATA_BASE_ADDR = 32'h1c80_0000;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  // True when every address bit above the word index and byte offset matches the base.
  function automatic logic in_window(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input int unsigned addr_w);
    logic [31:0] mask;
    mask = 32'hFFFF_FFFF << (addr_w + 32'd2);
    return ((addr ^ base) & mask) == 32'h0;
  endfunction

endpackage

// File: rtl/data_sram_resp_if.sv
// data_sram request/response bundle between the EX/MEM requester and the RAM
// responder; the flags travel with the bus.
interface data_sram_resp_if;

  logic        data_sram_en;
  logic [3:0]  data_sram_we;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        sram_ready;
  logic        sram_addr_err;

  modport master (
    output data_sram_en,
    output data_sram_we,
    output data_sram_addr,
    output data_sram_wdata,
    input  data_sram_rdata,
    input  sram_ready,
    input  sram_addr_err
  );

  modport slave (
    input  data_sram_en,
    input  data_sram_we,
    input  data_sram_addr,
    input  data_sram_wdata,
    output data_sram_rdata,
    output sram_ready,
    output sram_addr_err
  );

endinterface

// File: rtl/data_sram_resp_bank.sv
// DEPTH x 32 RAM with four byte-enable write lanes, a read-first registered port
// and a clear-write port that takes priority over the access port.
module data_sram_resp_bank #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              i_en,
  input  logic [3:0]        i_we,
  input  logic [ADDR_W-1:0] i_idx,
  input  logic [31:0]       i_wdata,
  input  logic              i_clr_en,
  input  logic [ADDR_W-1:0] i_clr_idx,
  output logic [31:0]       o_rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [31:0]       r_mem [DEPTH];
  logic [31:0]       r_q;
  logic [ADDR_W-1:0] w_wr_idx;
  logic [3:0]        w_wr_be;
  logic [31:0]       w_wr_data;

  // A single write port keeps the array BRAM-mappable.
  assign w_wr_idx  = i_clr_en ? i_clr_idx : i_idx;
  assign w_wr_be   = i_clr_en ? 4'hF : (i_en ? i_we : 4'h0);
  assign w_wr_data = i_clr_en ? 32'h0 : i_wdata;

  // NOTE: the array has no reset branch; zeroing is done by the clear sequencer,
  // which keeps the storage free of reset fan-out and inferable as block RAM.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (w_wr_be[i]) begin
        r_mem[w_wr_idx][8*i +: 8] <= w_wr_data[8*i +: 8];
      end
    end
    // NOTE: non-blocking assignment makes this read see the pre-write word,
    // which is exactly the read-first behaviour the requester expects.
    if (i_en && !i_clr_en) begin
      r_q <= r_mem[i_idx];
    end
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/data_sram_resp.sv
// Data RAM responder: post-reset clear sequencer, window decode, address error
// pulse and the rdata hold/zero logic around the byte-lane RAM bank.
module data_sram_resp
  import data_sram_resp_pkg::*;
#(
  parameter int unsigned ADDR_W         = DATA_ADDR_W,
  parameter logic [31:0] BASE_ADDR      = DATA_BASE_ADDR,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  data_sram_resp_if.slave   io_sram
);

  localparam logic [ADDR_W-1:0] LAST_IDX    = '1;
  localparam state_e            RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_READY;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [ADDR_W-1:0] r_clr_idx;
  logic              r_rd_from_mem;
  logic              r_err;

  logic              w_ready;
  logic              w_clr_en;
  logic              w_in_win;
  logic              w_acc;
  logic              w_bad;
  logic [ADDR_W-1:0] w_idx;
  logic [31:0]       w_bank_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= RESET_STATE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: the default assignment before the case keeps this block latch-free.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_CLEAR: if (r_clr_idx == LAST_IDX) w_state_nxt = ST_READY;
      ST_READY: w_state_nxt = ST_READY;
      default:  w_state_nxt = RESET_STATE;
    endcase
  end

  always_comb begin
    w_ready  = (r_state == ST_READY);
    w_clr_en = (r_state == ST_CLEAR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_clr_idx <= '0;
    end else if (w_clr_en) begin
      r_clr_idx <= r_clr_idx + 1'b1;
    end
  end

  assign w_idx    = io_sram.data_sram_addr[ADDR_W+1:2];
  assign w_in_win = in_window(io_sram.data_sram_addr, BASE_ADDR, ADDR_W);
  assign w_acc    = !reset && w_ready && io_sram.data_sram_en && w_in_win;
  assign w_bad    = w_ready && io_sram.data_sram_en && !w_in_win;

  // The bank holds its last read word; this flag decides whether rdata shows it
  // or zero (after reset, a dropped request or an out-of-window request).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_from_mem <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      if (io_sram.data_sram_en) begin
        r_rd_from_mem <= w_acc;
      end
      r_err <= w_bad;
    end
  end

  data_sram_resp_bank #(
    .ADDR_W (ADDR_W)
  ) u_bank (
    .clk       (clk),
    .i_en      (w_acc),
    .i_we      (io_sram.data_sram_we),
    .i_idx     (w_idx),
    .i_wdata   (io_sram.data_sram_wdata),
    .i_clr_en  (w_clr_en),
    .i_clr_idx (r_clr_idx),
    .o_rdata   (w_bank_q)
  );

  assign io_sram.data_sram_rdata = r_rd_from_mem ? w_bank_q : 32'h0;
  assign io_sram.sram_ready      = w_ready;
  assign io_sram.sram_addr_err   = r_err;

endmodule

// File: tb/tb_data_sram_resp.sv
// Scoreboard bench for data_sram_resp: a word-array reference model predicts each
// cycle's response, a posedge monitor pops and compares.
module tb_data_sram_resp;
  import data_sram_resp_pkg::*;

  localparam int unsigned ADDR_W = DATA_ADDR_W;
  localparam int          DEPTH  = 1 << ADDR_W;
  localparam logic [31:0] BASE   = DATA_BASE_ADDR;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        ready;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  data_sram_resp_if sram_if ();

  data_sram_resp #(
    .ADDR_W         (ADDR_W),
    .BASE_ADDR      (BASE),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .io_sram (sram_if)
  );

  exp_t        exp_q[$];
  int          n_checks    = 0;
  int          n_errors    = 0;
  logic [31:0] model_mem [DEPTH];
  logic [31:0] model_rdata = 32'h0;
  int          p_edges     = 0;
  int          mon_edges   = 0;
  int          ready_edge  = -1;
  logic [31:0] obs_rdata   = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one cycle and pushes the response the specification predicts for it.
  task automatic step(input bit rst, input bit en, input logic [3:0] we,
                      input logic [31:0] addr, input logic [31:0] wdata);
    exp_t e;
    int   idx;
    @(negedge clk);
    reset                   = rst;
    sram_if.data_sram_en    = en;
    sram_if.data_sram_we    = we;
    sram_if.data_sram_addr  = addr;
    sram_if.data_sram_wdata = wdata;
    if (rst) begin
      p_edges     = 0;
      model_rdata = 32'h0;
      foreach (model_mem[i]) model_mem[i] = 32'h0;
      e = '{rdata: 32'h0, err: 1'b0, ready: 1'b0};
    end else begin
      p_edges++;
      e.err = 1'b0;
      if (en) begin
        if (p_edges <= DEPTH) begin
          model_rdata = 32'h0;
        end else if ((addr >> (ADDR_W + 2)) == (BASE >> (ADDR_W + 2))) begin
          idx         = int'((addr >> 2) % DEPTH);
          model_rdata = model_mem[idx];
          for (int i = 0; i < 4; i++)
            if (we[i]) model_mem[idx][8*i +: 8] = wdata[8*i +: 8];
        end else begin
          model_rdata = 32'h0;
          e.err       = 1'b1;
        end
      end
      e.rdata = model_rdata;
      e.ready = (p_edges >= DEPTH);
    end
    exp_q.push_back(e);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic rd(input logic [31:0] addr);
    step(1'b0, 1'b1, 4'h0, addr, 32'h0);
  endtask

  task automatic wr(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wdata);
    step(1'b0, 1'b1, we, addr, wdata);
  endtask

  task automatic wait_ready();
    for (int i = 0; i < DEPTH + 20 && ready_edge < 0; i++) idle();
    check("ready_rise_edge", ready_edge, DEPTH);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (reset) begin
      mon_edges = 0;
    end else begin
      mon_edges++;
      if (sram_if.sram_ready && ready_edge < 0) ready_edge = mon_edges;
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("rdata", sram_if.data_sram_rdata, e.rdata);
      check("addr_err", {31'h0, sram_if.sram_addr_err}, {31'h0, e.err});
      check("ready", {31'h0, sram_if.sram_ready}, {31'h0, e.ready});
      obs_rdata = sram_if.data_sram_rdata;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] addr;
    logic [3:0]  we;
    sram_if.data_sram_en    = 1'b0;
    sram_if.data_sram_we    = 4'h0;
    sram_if.data_sram_addr  = 32'h0;
    sram_if.data_sram_wdata = 32'h0;

    step(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    wait_ready();
    rd(BASE);
    rd(BASE + 32'd20);
    rd(BASE + 32'((DEPTH - 1) * 4));

    wr(4'hF, BASE + 32'h10, 32'h1234_5678);
    rd(BASE + 32'h10);
    idle();
    check("full_word_read", obs_rdata, 32'h1234_5678);

    wr(4'b0100, BASE + 32'h10, 32'hAAAA_AAAA);
    rd(BASE + 32'h10);
    idle();
    check("lane2_merge", obs_rdata, 32'h12AA_5678);
    wr(4'b1100, BASE + 32'h10, 32'hBEEF_BEEF);
    rd(BASE + 32'h10);
    idle();
    check("lane32_merge", obs_rdata, 32'hBEEF_5678);

    wr(4'hF, BASE + 32'h20, 32'h1111_1111);
    wr(4'hF, BASE + 32'h20, 32'h2222_2222);
    idle();
    check("read_first_old", obs_rdata, 32'h1111_1111);
    rd(BASE + 32'h20);
    idle();
    check("read_after_write", obs_rdata, 32'h2222_2222);

    wr(4'hF, 32'h0000_0040, 32'hDEAD_BEEF);
    idle();
    check("oow_rdata_zero", obs_rdata, 32'h0);
    idle();
    idle();
    rd(BASE + 32'h40);
    rd(32'h0000_0040);
    rd(BASE + 32'h10);
    idle();
    check("oow_no_modify", obs_rdata, 32'hBEEF_5678);

    for (int n = 0; n < 400; n++) begin
      addr = BASE | (32'($urandom_range(15)) << 2) | 32'($urandom_range(3));
      if ($urandom_range(7) == 0)
        addr = addr ^ (32'h1 << (ADDR_W + 2 + 32'($urandom_range(31 - ADDR_W - 2))));
      we = ($urandom_range(2) == 0) ? 4'h0 : 4'($urandom);
      step(1'b0, $urandom_range(3) != 0, we, addr, $urandom);
    end

    step(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    for (int i = 0; i < 100; i++) idle();
    ready_edge = -1;
    step(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    for (int i = 0; i < 500; i++) idle();
    wr(4'hF, BASE + 32'h1C, 32'hCAFE_F00D);
    wait_ready();
    rd(BASE + 32'h1C);
    idle();
    check("clear_write_lost", obs_rdata, 32'h0);

    idle();
    for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
